// File: rtl/sky130_sram_1rw1r_pipe.sv
// Parametrised 1RW+1R SRAM behavioural macro with selectable read latency, valid strobes
// and defined same-address collision handling. Optional per-lane parity: SKY130_SRAM_PARITY_EN.
module sky130_sram_1rw1r_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int WMASK_WIDTH    = 8,
  parameter int READ_LATENCY   = 1,
  parameter int COLLISION_MODE = 0
) (
  input  logic                               clk0,
  input  logic                               rstb0,
  input  logic                               csb0,
  input  logic                               web0,
  input  logic [DATA_WIDTH/WMASK_WIDTH-1:0]  wmask0,
  input  logic [ADDR_WIDTH-1:0]              addr0,
  input  logic [DATA_WIDTH-1:0]              din0,
  output logic [DATA_WIDTH-1:0]              dout0,
  output logic                               dout0_valid,
  input  logic                               csb1,
  input  logic [ADDR_WIDTH-1:0]              addr1,
  output logic [DATA_WIDTH-1:0]              dout1,
  output logic                               dout1_valid,
`ifdef SKY130_SRAM_PARITY_EN
  output logic [DATA_WIDTH/WMASK_WIDTH-1:0]  perr0,
  output logic [DATA_WIDTH/WMASK_WIDTH-1:0]  perr1,
`endif
  output logic                               collision
);
  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [NUM_WMASKS-1:0] lane_t;

  function automatic word_t merge_lanes(input word_t old_w, input word_t new_w, input lane_t m);
    word_t r;
    r = old_w;
    for (int i = 0; i < NUM_WMASKS; i++)
      if (m[i]) r[i*WMASK_WIDTH +: WMASK_WIDTH] = new_w[i*WMASK_WIDTH +: WMASK_WIDTH];
    return r;
  endfunction

  word_t mem_q [RAM_DEPTH];

  logic  wr_en, rd0_en, rd1_en, coll_hit;
  word_t req_data0, req_data1;

  always_comb begin
    wr_en     = !csb0 && !web0;
    rd0_en    = !csb0 && web0;
    rd1_en    = !csb1;
    coll_hit  = rd1_en && wr_en && (addr0 == addr1);
    req_data0 = mem_q[addr0];
    req_data1 = mem_q[addr1];
    // Mode 1 forwards the write being applied on this same edge into the port-1 read.
    if (COLLISION_MODE == 1 && coll_hit)
      req_data1 = merge_lanes(mem_q[addr1], din0, wmask0);
  end

  // Array is deliberately not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk0) begin
    if (rstb0 && wr_en)
      for (int i = 0; i < NUM_WMASKS; i++)
        if (wmask0[i]) mem_q[addr0][i*WMASK_WIDTH +: WMASK_WIDTH] <= din0[i*WMASK_WIDTH +: WMASK_WIDTH];
  end

`ifdef SKY130_SRAM_PARITY_EN
  function automatic lane_t lane_parity(input word_t w);
    lane_t p;
    for (int i = 0; i < NUM_WMASKS; i++) p[i] = ^w[i*WMASK_WIDTH +: WMASK_WIDTH];
    return p;
  endfunction

  lane_t par_q [RAM_DEPTH];
  lane_t req_perr0, req_perr1, par1_exp;

  always_comb begin
    par1_exp = par_q[addr1];
    if (COLLISION_MODE == 1 && coll_hit)
      par1_exp = (lane_parity(din0) & wmask0) | (par_q[addr1] & ~wmask0);
    req_perr0 = lane_parity(req_data0) ^ par_q[addr0];
    req_perr1 = lane_parity(req_data1) ^ par1_exp;
  end

  always_ff @(posedge clk0) begin
    if (rstb0 && wr_en)
      for (int i = 0; i < NUM_WMASKS; i++)
        if (wmask0[i]) par_q[addr0][i] <= ^din0[i*WMASK_WIDTH +: WMASK_WIDTH];
  end
`endif

  logic  src_vld0, src_vld1, src_coll;
  word_t src_data0, src_data1;
`ifdef SKY130_SRAM_PARITY_EN
  lane_t src_perr0, src_perr1;
`endif

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic  vld0_p1_q, vld1_p1_q, coll_p1_q;
      word_t data0_p1_q, data1_p1_q;
`ifdef SKY130_SRAM_PARITY_EN
      lane_t perr0_p1_q, perr1_p1_q;
`endif
      // Stage p1: array read captured at edge E, presented after edge E+1.
      always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
          vld0_p1_q  <= 1'b0;
          vld1_p1_q  <= 1'b0;
          coll_p1_q  <= 1'b0;
          data0_p1_q <= '0;
          data1_p1_q <= '0;
`ifdef SKY130_SRAM_PARITY_EN
          perr0_p1_q <= '0;
          perr1_p1_q <= '0;
`endif
        end else begin
          vld0_p1_q  <= rd0_en;
          vld1_p1_q  <= rd1_en;
          coll_p1_q  <= coll_hit;
          data0_p1_q <= req_data0;
          data1_p1_q <= req_data1;
`ifdef SKY130_SRAM_PARITY_EN
          perr0_p1_q <= req_perr0;
          perr1_p1_q <= req_perr1;
`endif
        end
      end
      assign src_vld0  = vld0_p1_q;
      assign src_vld1  = vld1_p1_q;
      assign src_coll  = coll_p1_q;
      assign src_data0 = data0_p1_q;
      assign src_data1 = data1_p1_q;
`ifdef SKY130_SRAM_PARITY_EN
      assign src_perr0 = perr0_p1_q;
      assign src_perr1 = perr1_p1_q;
`endif
    end else begin : g_lat1
      assign src_vld0  = rd0_en;
      assign src_vld1  = rd1_en;
      assign src_coll  = coll_hit;
      assign src_data0 = req_data0;
      assign src_data1 = req_data1;
`ifdef SKY130_SRAM_PARITY_EN
      assign src_perr0 = req_perr0;
      assign src_perr1 = req_perr1;
`endif
    end
  endgenerate

  word_t dout0_d, dout0_q, dout1_d, dout1_q;
  logic  dout0_valid_d, dout0_valid_q, dout1_valid_d, dout1_valid_q, collision_d, collision_q;
`ifdef SKY130_SRAM_PARITY_EN
  lane_t perr0_d, perr0_q, perr1_d, perr1_q;
`endif

  always_comb begin
    dout0_d       = src_vld0 ? src_data0 : dout0_q;
    dout1_d       = src_vld1 ? src_data1 : dout1_q;
    dout0_valid_d = src_vld0;
    dout1_valid_d = src_vld1;
    collision_d   = src_coll;
`ifdef SKY130_SRAM_PARITY_EN
    perr0_d       = src_vld0 ? src_perr0 : '0;
    perr1_d       = src_vld1 ? src_perr1 : '0;
`endif
  end

  // Output stage: data holds between reads, strobes are single-cycle.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      dout0_q       <= '0;
      dout1_q       <= '0;
      dout0_valid_q <= 1'b0;
      dout1_valid_q <= 1'b0;
      collision_q   <= 1'b0;
`ifdef SKY130_SRAM_PARITY_EN
      perr0_q       <= '0;
      perr1_q       <= '0;
`endif
    end else begin
      dout0_q       <= dout0_d;
      dout1_q       <= dout1_d;
      dout0_valid_q <= dout0_valid_d;
      dout1_valid_q <= dout1_valid_d;
      collision_q   <= collision_d;
`ifdef SKY130_SRAM_PARITY_EN
      perr0_q       <= perr0_d;
      perr1_q       <= perr1_d;
`endif
    end
  end

  assign dout0       = dout0_q;
  assign dout1       = dout1_q;
  assign dout0_valid = dout0_valid_q;
  assign dout1_valid = dout1_valid_q;
  assign collision   = collision_q;
`ifdef SKY130_SRAM_PARITY_EN
  assign perr0       = perr0_q;
  assign perr1       = perr1_q;
`endif
endmodule
